// File: rtl/tm_input_conditioner.sv
// tm_input_conditioner: front end that conditions the board buttons and switches
// for the Turing machine core.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   btn_next_raw   raw asynchronous Next button
//   btn_done_raw   raw asynchronous Done button
//   sw_data_raw    raw asynchronous data switches (DW bits)
//   next_out       conditioned Next level, drives the core's Next
//   done_out       conditioned Done level, drives the core's Done
//   data_out       word captured when a Next press is accepted
//   word_count     number of words accepted while loading
//   overflow       sticky, set when a Next press was rejected because the buffer was full
//   running        high once Done has been accepted
module tm_input_conditioner #(
    parameter int DW              = 4,
    parameter int MAX_WORDS       = 64,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           btn_next_raw,
    input  logic                           btn_done_raw,
    input  logic [DW-1:0]                  sw_data_raw,
    output logic                           next_out,
    output logic                           done_out,
    output logic [DW-1:0]                  data_out,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
    output logic                           overflow,
    output logic                           running
);

    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int WCW = $clog2(MAX_WORDS + 1);

    typedef enum logic {LOAD, RUN} state_t;

    // Index 0 is Next, index 1 is Done.
    logic [1:0]    btn_s1, btn_s2, deb, tog;
    logic [CW-1:0] cnt [2];
    logic [DW-1:0] sw_s1, sw_s2;

    state_t         state, state_n;
    logic           next_acc, next_acc_n;
    logic           next_out_n, done_out_n;
    logic [DW-1:0]  data_n;
    logic [WCW-1:0] count_n;
    logic           ovf_n;
    logic           next_rise, next_fall, done_rise;

    // A toggle fires on the last cycle of a full stable mismatch window.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            tog[i] = (btn_s2[i] != deb[i]) &&
                     (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    assign next_rise = tog[0] & ~deb[0];
    assign next_fall = tog[0] &  deb[0];
    assign done_rise = tog[1] & ~deb[1];
    assign running   = (state == RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            deb        <= '0;
            cnt[0]     <= '0;
            cnt[1]     <= '0;
            state      <= LOAD;
            next_acc   <= 1'b0;
            next_out   <= 1'b0;
            done_out   <= 1'b0;
            data_out   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            btn_s1 <= {btn_done_raw, btn_next_raw};
            btn_s2 <= btn_s1;
            sw_s1  <= sw_data_raw;
            sw_s2  <= sw_s1;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (tog[i]) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            state      <= state_n;
            next_acc   <= next_acc_n;
            next_out   <= next_out_n;
            done_out   <= done_out_n;
            data_out   <= data_n;
            word_count <= count_n;
            overflow   <= ovf_n;
        end
    end

    // next_acc marks a press accepted on the debounce edge; next_out
    // follows it one cycle later so data_out is stable before it rises.
    always_comb begin
        state_n    = state;
        next_acc_n = next_acc;
        next_out_n = deb[0];
        done_out_n = deb[1];
        data_n     = data_out;
        count_n    = word_count;
        ovf_n      = overflow;
        unique case (state)
            LOAD: begin
                next_out_n = next_acc;
                done_out_n = 1'b0;
                if (next_fall) begin
                    next_acc_n = 1'b0;
                end
                if (next_rise) begin
                    if (word_count < WCW'(MAX_WORDS)) begin
                        next_acc_n = 1'b1;
                        data_n     = sw_s2;
                        count_n    = word_count + WCW'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else if (done_rise && (word_count != '0) &&
                             !next_out && !next_acc) begin
                    state_n = RUN;
                end
            end
            RUN: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tm_input_conditioner.sv
// tb_tm_input_conditioner: directed bench for tm_input_conditioner
// with DEBOUNCE_CYCLES=4, MAX_WORDS=3, DW=4.
module tb_tm_input_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_next_raw, btn_done_raw;
    logic [3:0] sw_data_raw;
    logic       next_out, done_out, overflow, running;
    logic [3:0] data_out;
    logic [1:0] word_count;

    int errors = 0;
    int checks = 0;
    bit seen;
    bit bad;

    tm_input_conditioner #(
        .DW(4), .MAX_WORDS(3), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_next_raw(btn_next_raw),
        .btn_done_raw(btn_done_raw),
        .sw_data_raw(sw_data_raw),
        .next_out(next_out),
        .done_out(done_out),
        .data_out(data_out),
        .word_count(word_count),
        .overflow(overflow),
        .running(running)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        btn_next_raw = 1'b0;
        btn_done_raw = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_next"}, next_out, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_wc"}, word_count, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_run"}, running, 0);
    endtask

    // Hold Next for 'hold' cycles, then release and let it settle.
    // 'seen' records whether next_out was ever high.
    task automatic press_next(input logic [3:0] sw, input int hold);
        sw_data_raw  = sw;
        btn_next_raw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < hold + 10; i++) begin
            if (i == hold) btn_next_raw = 1'b0;
            tick();
            if (next_out) seen = 1'b1;
        end
    endtask

    initial begin
        sw_data_raw = 4'h0;
        do_reset();
        check_all_zero("reset");

        // 1: basic press, latency and release.
        sw_data_raw  = 4'hA;
        btn_next_raw = 1'b1;
        tick(6);
        check("t1_pre", next_out, 0);
        tick();
        check("t1_rise", next_out, 1);
        check("t1_data", data_out, 4'hA);
        check("t1_wc", word_count, 1);
        tick(13);
        btn_next_raw = 1'b0;
        tick(6);
        check("t1_hold", next_out, 1);
        tick();
        check("t1_fall", next_out, 0);
        check("t1_wc2", word_count, 1);

        // 2: glitches shorter than the window are dropped; exactly D passes.
        do_reset();
        press_next(4'h7, 2);
        check("t2_pulse2", seen, 0);
        press_next(4'h7, 3);
        check("t2_pulse3", seen, 0);
        check("t2_wc", word_count, 0);
        press_next(4'h6, 4);
        check("t2_pulse4", seen, 1);
        check("t2_wc4", word_count, 1);
        check("t2_data4", data_out, 6);

        // 3: switch changes during a press are ignored.
        do_reset();
        sw_data_raw  = 4'h3;
        btn_next_raw = 1'b1;
        tick(7);
        check("t3_rise", next_out, 1);
        sw_data_raw = 4'h5;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (next_out && data_out != 4'h3) bad = 1'b1;
        end
        btn_next_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (next_out && data_out != 4'h3) bad = 1'b1;
        end
        check("t3_frozen", bad, 0);
        check("t3_data", data_out, 4'h3);

        // 4: capacity and sticky overflow.
        do_reset();
        press_next(4'h1, 10);
        press_next(4'h2, 10);
        press_next(4'h3, 10);
        check("t4_wc3", word_count, 3);
        check("t4_data3", data_out, 3);
        check("t4_ovf0", overflow, 0);
        press_next(4'h4, 10);
        check("t4_rej_next", seen, 0);
        check("t4_ovf1", overflow, 1);
        check("t4_wc_sat", word_count, 3);
        check("t4_data_keep", data_out, 3);
        press_next(4'h5, 10);
        check("t4_ovf_sticky", overflow, 1);

        // 5: Done gating, then RUN passthrough.
        do_reset();
        btn_done_raw = 1'b1;
        tick(12);
        check("t5_done_empty", done_out, 0);
        check("t5_run_empty", running, 0);
        btn_done_raw = 1'b0;
        tick(10);
        press_next(4'h7, 10);
        check("t5_wc1", word_count, 1);
        btn_done_raw = 1'b1;
        tick(6);
        check("t5_done_pre", done_out, 0);
        tick();
        check("t5_done", done_out, 1);
        check("t5_run", running, 1);
        press_next(4'h9, 10);
        check("t5_run_next", seen, 1);
        check("t5_run_wc", word_count, 1);
        check("t5_run_data", data_out, 7);
        btn_done_raw = 1'b0;
        tick(8);
        check("t5_done_rel", done_out, 0);
        check("t5_run_stay", running, 1);

        // 6: simultaneous rise, then reset with Next still held.
        do_reset();
        press_next(4'h1, 10);
        press_next(4'h2, 10);
        check("t6_wc2", word_count, 2);
        sw_data_raw  = 4'h6;
        btn_next_raw = 1'b1;
        btn_done_raw = 1'b1;
        tick(7);
        check("t6_next", next_out, 1);
        check("t6_done", done_out, 0);
        tick(5);
        check("t6_done2", done_out, 0);
        check("t6_run", running, 0);
        btn_done_raw = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("t6_rst");
        tick(6);
        check("t6_pre", next_out, 0);
        tick();
        check("t6_again", next_out, 1);
        check("t6_wc_again", word_count, 1);
        check("t6_data_again", data_out, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
